// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3/error encodings and FSM state type for the load/store controller
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_MISAL = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;
  localparam logic [1:0] ERR_ILL   = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_MERGE, S_RESP} state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: little-endian lane extract/extend for loads and lane merge for sub-word stores
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] merge_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);
  logic [15:0] lo;
  logic [31:0] mask;
  logic [31:0] spread;
  // halfword accesses are always half-aligned here, so byte-lane shift also serves halves
  always_comb begin
    lo      = 16'(rdata_i >> {lane_i, 3'b000});
    load_o  = funct3_i == F3_B  ? {{24{lo[7]}}, lo[7:0]} :
              funct3_i == F3_H  ? {{16{lo[15]}}, lo} :
              funct3_i == F3_BU ? {24'b0, lo[7:0]} :
              funct3_i == F3_HU ? {16'b0, lo} : rdata_i;
    mask    = (funct3_i == F3_H ? 32'h0000_ffff : 32'h0000_00ff) << {lane_i, 3'b000};
    spread  = funct3_i == F3_H ? {2{wdata_i}} : {4{wdata_i[7:0]}};
    merge_o = (merge_i & ~mask) | (spread & mask);
  end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: validating load/store controller with read-modify-write for byte/half stores
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic [1:0]        resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  localparam logic [ADDR_W-1:0] WORD_LIMIT = ADDR_W'(MEM_WORDS);
  state_t            state_q, state_d;
  logic              store_q, store_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       merge_q, merge_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        err_q, err_d;
  logic              ill, misal, range_err;
  logic [1:0]        chk_err;
  logic [31:0]       load_data, merge_data;
  lsu_align u_align (
    .funct3_i (f3_q),
    .lane_i   (addr_q[1:0]),
    .rdata_i  (mem_rdata),
    .merge_i  (merge_q),
    .wdata_i  (wdata_q[15:0]),
    .load_o   (load_data),
    .merge_o  (merge_data)
  );
  always_comb begin
    ill       = req_store ? !(req_funct3 == F3_B || req_funct3 == F3_H || req_funct3 == F3_W)
                          : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
    misal     = ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0]) ||
                (req_funct3 == F3_W && req_addr[1:0] != 2'b00);
    range_err = {2'b00, req_addr[ADDR_W-1:2]} >= WORD_LIMIT;
    chk_err   = ill ? ERR_ILL : misal ? ERR_MISAL : range_err ? ERR_RANGE : ERR_OK;
  end
  always_comb begin
    state_d = state_q;
    store_d = store_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        store_d = req_store;
        f3_d    = req_funct3;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        rdata_d = '0;
        err_d   = chk_err;
        state_d = chk_err != ERR_OK ? S_RESP : S_ACCESS;
      end
      S_ACCESS: begin
        rdata_d = store_q ? rdata_q : load_data;
        merge_d = mem_rdata;
        state_d = store_q && f3_q != F3_W ? S_MERGE : S_RESP;
      end
      S_MERGE: state_d = S_RESP;
      S_RESP:  state_d = resp_ready ? S_IDLE : S_RESP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      store_q <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  // memory strobes are masked by reset so an abandoned transaction never writes
  always_comb begin
    req_ready  = state_q == S_IDLE;
    resp_valid = !reset && state_q == S_RESP;
    resp_rdata = rdata_q;
    resp_err   = err_q;
    mem_read   = !reset && state_q == S_ACCESS;
    mem_write  = !reset && ((state_q == S_ACCESS && store_q && f3_q == F3_W) || state_q == S_MERGE);
    mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    mem_wdata  = !mem_write ? '0 : state_q == S_MERGE ? merge_data : wdata_q;
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: table-driven check of lsu_ctrl against a 256-word memory model
module tb_lsu_ctrl;
  logic        clk = 1'b0;
  logic        reset, preload;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [256];
  logic [31:0] last_wdata;
  int          wr_total;
  int          n_chk, n_fail;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_err;
    int          exp_lat;
    int          exp_wr;
    logic [31:0] exp_wdata;
  } vec_t;
  vec_t vecs [18];

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_W(32), .MEM_WORDS(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[16] <= 32'h8899aabb;
      mem[4]  <= 32'h12345678;
    end else if (mem_write) begin
      mem[mem_addr[9:2]] <= mem_wdata;
      last_wdata <= mem_wdata;
      wr_total <= wr_total + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat, rd, wr;
    @(negedge clk);
    drive(v.st, v.f3, v.addr, v.wdata);
    chk($sformatf("v%0d req_ready", idx), 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; rd = 0; wr = 0;
    while (!resp_valid && lat < 8) begin
      rd += int'(mem_read);
      wr += int'(mem_write);
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("v%0d rdata", idx), resp_rdata, v.exp_rdata);
    chk($sformatf("v%0d err", idx), 32'(resp_err), 32'(v.exp_err));
    chk($sformatf("v%0d reads", idx), 32'(rd), v.exp_err == 2'b00 ? 32'd1 : 32'd0);
    chk($sformatf("v%0d writes", idx), 32'(wr), 32'(v.exp_wr));
    chk($sformatf("v%0d resp_strobes", idx), {29'b0, req_ready, mem_read, mem_write}, 32'd0);
    if (v.exp_wr > 0) chk($sformatf("v%0d wdata", idx), last_wdata, v.exp_wdata);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk($sformatf("v%0d idle", idx), {30'b0, req_ready, resp_valid}, 32'd2);
  endtask

  initial begin
    int lat, wr_before;
    n_chk = 0; n_fail = 0;
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0;
    vecs[0]  = '{1'b0, 3'b000, 32'h041, 32'h0,        32'hffffffaa, 2'b00, 2, 0, 32'h0};
    vecs[1]  = '{1'b0, 3'b100, 32'h043, 32'h0,        32'h00000088, 2'b00, 2, 0, 32'h0};
    vecs[2]  = '{1'b0, 3'b001, 32'h042, 32'h0,        32'hffff8899, 2'b00, 2, 0, 32'h0};
    vecs[3]  = '{1'b0, 3'b101, 32'h040, 32'h0,        32'h0000aabb, 2'b00, 2, 0, 32'h0};
    vecs[4]  = '{1'b0, 3'b010, 32'h040, 32'h0,        32'h8899aabb, 2'b00, 2, 0, 32'h0};
    vecs[5]  = '{1'b1, 3'b000, 32'h042, 32'h11,       32'h0,        2'b00, 3, 1, 32'h8811aabb};
    vecs[6]  = '{1'b0, 3'b010, 32'h040, 32'h0,        32'h8811aabb, 2'b00, 2, 0, 32'h0};
    vecs[7]  = '{1'b0, 3'b001, 32'h041, 32'h0,        32'h0,        2'b01, 1, 0, 32'h0};
    vecs[8]  = '{1'b1, 3'b010, 32'h402, 32'h5,        32'h0,        2'b01, 1, 0, 32'h0};
    vecs[9]  = '{1'b0, 3'b010, 32'h400, 32'h0,        32'h0,        2'b10, 1, 0, 32'h0};
    vecs[10] = '{1'b1, 3'b100, 32'h401, 32'h7,        32'h0,        2'b11, 1, 0, 32'h0};
    vecs[11] = '{1'b0, 3'b011, 32'h040, 32'h0,        32'h0,        2'b11, 1, 0, 32'h0};
    vecs[12] = '{1'b1, 3'b001, 32'h012, 32'h9999cafe, 32'h0,        2'b00, 3, 1, 32'hcafe5678};
    vecs[13] = '{1'b1, 3'b010, 32'h010, 32'hdeadbeef, 32'h0,        2'b00, 2, 1, 32'hdeadbeef};
    vecs[14] = '{1'b0, 3'b000, 32'h013, 32'h0,        32'hffffffde, 2'b00, 2, 0, 32'h0};
    vecs[15] = '{1'b0, 3'b101, 32'h012, 32'h0,        32'h0000dead, 2'b00, 2, 0, 32'h0};
    vecs[16] = '{1'b1, 3'b000, 32'h3ff, 32'h123456a5, 32'h0,        2'b00, 3, 1, 32'ha5000000};
    vecs[17] = '{1'b0, 3'b100, 32'h3ff, 32'h0,        32'h000000a5, 2'b00, 2, 0, 32'h0};

    reset = 1'b1; preload = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", {28'b0, resp_valid, mem_read, mem_write, 1'b0}, 32'd0);
    chk("reset rdata", resp_rdata, 32'd0);
    chk("reset err", 32'(resp_err), 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0; preload = 1'b0;
    chk("reset req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 18; i++) run_vec(i, vecs[i]);

    // response held off: a pending store must not be accepted
    @(negedge clk);
    drive(1'b0, 3'b010, 32'h040, 32'h0);
    @(posedge clk); #1;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hold latency", 32'(lat), 32'd2);
    wr_before = wr_total;
    drive(1'b1, 3'b010, 32'h040, 32'h0);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("hold%0d valid", c), {30'b0, resp_valid, req_ready}, 32'd2);
      chk($sformatf("hold%0d rdata", c), resp_rdata, 32'h8811aabb);
      chk($sformatf("hold%0d err", c), 32'(resp_err), 32'd0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("hold release", {29'b0, req_ready, resp_valid, mem_read}, 32'd4);
    chk("hold no write", 32'(wr_total), 32'(wr_before));

    // reset while in MERGE of SH 0x10
    @(negedge clk);
    drive(1'b1, 3'b001, 32'h010, 32'h1234);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("merge reached", 32'(mem_write), 32'd1);
    wr_before = wr_total;
    reset = 1'b1;
    #1;
    chk("reset in merge write", 32'(mem_write), 32'd0);
    @(posedge clk); #1;
    chk("mid reset strobes", {29'b0, resp_valid, mem_read, mem_write}, 32'd0);
    chk("mid reset rdata", resp_rdata, 32'd0);
    chk("mid reset err", 32'(resp_err), 32'd0);
    chk("mid reset addr", mem_addr, 32'd0);
    chk("mid reset wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    chk("post reset ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    chk("post reset strobes", {29'b0, resp_valid, mem_read, mem_write}, 32'd0);
    chk("post reset writes", 32'(wr_total), 32'(wr_before));
    chk("post reset mem", mem[4], 32'hdeadbeef);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
